// File: rtl/vector_spi_loader.sv
// Write-only SPI (mode 0) receiver for a 6-vector view-state frame. A complete frame is staged
// on new_* and write_new_position is held high until the renderer's frame tick consumes it.
module vector_spi_loader #(
  parameter int unsigned QMN        = 24,
  parameter int unsigned NVEC       = 6,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tick,
  input  logic           spi_sclk,
  input  logic           spi_mosi,
  input  logic           spi_csb,
  output logic           write_new_position,
  output logic [QMN-1:0] new_playerX,
  output logic [QMN-1:0] new_playerY,
  output logic [QMN-1:0] new_facingX,
  output logic [QMN-1:0] new_facingY,
  output logic [QMN-1:0] new_vplaneX,
  output logic [QMN-1:0] new_vplaneY,
  output logic           frame_error,
  output logic           busy
);

  localparam int unsigned FRAME_BITS = QMN * NVEC;
  localparam int unsigned CW         = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DROP} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_DEPTH-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_DEPTH-1:0]   mosi_sync_q, mosi_sync_d;
  logic [SYNC_DEPTH-1:0]   csb_sync_q, csb_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    csb_prev_q, csb_prev_d;
  logic                    armed_q, armed_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   stage_q, stage_d;
  logic                    pending_q, pending_d;

  logic sclk_s, mosi_s, csb_s;
  logic sclk_rise, csb_rise, csb_fall;

  assign sclk_s    = sclk_sync_q[SYNC_DEPTH-1];
  assign mosi_s    = mosi_sync_q[SYNC_DEPTH-1];
  assign csb_s     = csb_sync_q[SYNC_DEPTH-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign csb_rise  = csb_s & ~csb_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_DEPTH-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_DEPTH-2:0], spi_mosi};
    csb_sync_d  = {csb_sync_q[SYNC_DEPTH-2:0], spi_csb};
    sclk_prev_d = sclk_s;
    csb_prev_d  = csb_s;
    // Synchronisers reset low so a frame already running at reset release never arms the loader.
    armed_d     = armed_q | csb_s;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    stage_d   = stage_q;
    pending_d = pending_q;
    if (tick && pending_q) pending_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (csb_fall && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (csb_rise) begin
          state_d = (cnt_q == CW'(FRAME_BITS)) ? COMMIT : DROP;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != CW'(FRAME_BITS + 1)) cnt_d = cnt_q + CW'(1);
        end
      end
      COMMIT: begin
        // A commit coinciding with a tick re-arms pending for the freshly staged frame.
        stage_d   = shift_q;
        pending_d = 1'b1;
        state_d   = IDLE;
      end
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csb_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      stage_q     <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      csb_sync_q  <= csb_sync_d;
      sclk_prev_q <= sclk_prev_d;
      csb_prev_q  <= csb_prev_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      stage_q     <= stage_d;
      pending_q   <= pending_d;
    end
  end

  assign write_new_position = pending_q;
  assign frame_error        = (state_q == DROP);
  assign busy               = (state_q == SHIFT);
  assign new_playerX        = stage_q[5*QMN +: QMN];
  assign new_playerY        = stage_q[4*QMN +: QMN];
  assign new_facingX        = stage_q[3*QMN +: QMN];
  assign new_facingY        = stage_q[2*QMN +: QMN];
  assign new_vplaneX        = stage_q[1*QMN +: QMN];
  assign new_vplaneY        = stage_q[0 +: QMN];

endmodule

// File: tb/tb_vector_spi_loader.sv
// Directed bench for vector_spi_loader: table of SPI frames plus hand-written sequences for
// tick/commit collision, reset mid-frame and sclk activity with chip select high.
`timescale 1ns/1ps
module tb_vector_spi_loader;

  logic         clk = 1'b0;
  logic         reset_n, tick, spi_sclk, spi_mosi, spi_csb;
  logic         write_new_position, frame_error, busy;
  logic [23:0]  new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY;
  logic [143:0] new_all;

  always #5 clk = ~clk;

  vector_spi_loader #(.QMN(24), .NVEC(6), .SYNC_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_csb(spi_csb),
    .write_new_position(write_new_position),
    .new_playerX(new_playerX), .new_playerY(new_playerY),
    .new_facingX(new_facingX), .new_facingY(new_facingY),
    .new_vplaneX(new_vplaneX), .new_vplaneY(new_vplaneY),
    .frame_error(frame_error), .busy(busy)
  );

  assign new_all = {new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY};

  int checks = 0;
  int errors = 0;

  // Renderer model: loads new_* at the edge where tick && write_new_position.
  logic [143:0] cap_q = '0;
  int           cap_n = 0;
  always @(posedge clk) begin
    if (reset_n && tick && write_new_position) begin
      cap_q <= new_all;
      cap_n <= cap_n + 1;
    end
  end

  int   err_pulses = 0;
  int   err_long   = 0;
  logic err_prev   = 1'b0;
  always @(negedge clk) begin
    if (frame_error) begin
      err_pulses++;
      if (err_prev) err_long++;
    end
    err_prev = frame_error;
  end

  typedef struct {
    logic [159:0] data;
    int unsigned  nbits;
    logic         tick_after;
    logic [143:0] exp_new;
    logic         exp_pend;
    int           exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    @(negedge clk);
    spi_mosi = b;
    cyc(2);
    spi_sclk = 1'b1;
    cyc(3);
    spi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [159:0] d, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) spi_bit(d[i]);
  endtask

  task automatic csb_low();
    @(negedge clk);
    spi_csb = 1'b0;
    cyc(3);
  endtask

  task automatic csb_high();
    cyc(3);
    spi_csb = 1'b1;
  endtask

  logic [159:0] f1, a2, a3, b1, b2, c1, junk;
  int e0, c0, bad_busy;

  initial begin
    reset_n = 1'b0; tick = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_csb = 1'b1;
    f1   = {16'h0, 24'h001800, 24'h00D800, 24'h000000, 24'hFFF000, 24'h000800, 24'h000000};
    a2   = {16'h0, 24'h002000, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    a3   = {16'h0, 24'h003000, 24'hABCDEF, 24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF};
    b1   = {16'h0, 24'h004000, 24'h010101, 24'h020202, 24'h030303, 24'h040404, 24'h050505};
    b2   = {16'h0, 24'h005000, 24'hA0A0A0, 24'hB0B0B0, 24'hC0C0C0, 24'hD0D0D0, 24'hE0E0E0};
    c1   = {16'h0, 24'h006000, 24'hFEDCBA, 24'h135791, 24'h2468AC, 24'hF00F00, 24'h0FF0FF};
    junk = 160'h9C3E_5A5A_C3C3_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A;

    vecs[0] = '{f1,   144, 1'b1, f1[143:0], 1'b1, 0};
    vecs[1] = '{junk, 143, 1'b0, f1[143:0], 1'b0, 1};
    vecs[2] = '{junk, 145, 1'b0, f1[143:0], 1'b0, 1};
    vecs[3] = '{a2,   144, 1'b0, a2[143:0], 1'b1, 0};
    vecs[4] = '{a3,   144, 1'b1, a3[143:0], 1'b1, 0};

    cyc(4);
    chk("rst_wnp", write_new_position, 0);
    chk("rst_new", new_all, 0);
    chk("rst_err", frame_error, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    cyc(5);

    // Tick with nothing pending
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("idle_tick_wnp", write_new_position, 0);
    chk("idle_tick_cap", cap_n, 0);

    for (int v = 0; v < 5; v++) begin
      e0 = err_pulses;
      csb_low();
      send_bits(vecs[v].data, vecs[v].nbits);
      chk($sformatf("v%0d_busy", v), busy, 1);
      csb_high();
      cyc(4);
      chk($sformatf("v%0d_pend", v), write_new_position, vecs[v].exp_pend);
      chk($sformatf("v%0d_new", v), new_all, vecs[v].exp_new);
      cyc(3);
      chk($sformatf("v%0d_err", v), err_pulses - e0, vecs[v].exp_err);
      if (vecs[v].tick_after) begin
        c0 = cap_n;
        tick = 1'b1;
        chk($sformatf("v%0d_pend_at_tick", v), write_new_position, 1);
        cyc(1);
        tick = 1'b0;
        chk($sformatf("v%0d_pend_after_tick", v), write_new_position, 0);
        chk($sformatf("v%0d_cap", v), cap_q, vecs[v].exp_new);
        chk($sformatf("v%0d_cap_n", v), cap_n - c0, 1);
      end
    end

    // Commit lands on the same clk as a tick with a prior frame pending
    csb_low(); send_bits(b1, 144); csb_high(); cyc(7);
    chk("t4_b1_pend", write_new_position, 1);
    chk("t4_b1_new", new_all, b1[143:0]);
    csb_low(); send_bits(b2, 144); csb_high();
    cyc(3);
    tick = 1'b1;
    c0 = cap_n;
    chk("t4_old_pend", write_new_position, 1);
    chk("t4_old_new", new_all, b1[143:0]);
    cyc(1);
    tick = 1'b0;
    chk("t4_new_new", new_all, b2[143:0]);
    chk("t4_pend_kept", write_new_position, 1);
    chk("t4_cap_old", cap_q, b1[143:0]);
    chk("t4_cap_n", cap_n - c0, 1);

    // Reset mid-frame, chip select held low across release
    e0 = err_pulses;
    csb_low();
    send_bits(f1 >> 74, 70);
    reset_n = 1'b0;
    cyc(3);
    chk("t5_rst_wnp", write_new_position, 0);
    chk("t5_rst_new", new_all, 0);
    reset_n = 1'b1;
    cyc(3);
    send_bits(f1, 74);
    chk("t5_busy", busy, 0);
    csb_high();
    cyc(8);
    chk("t5_no_commit", write_new_position, 0);
    chk("t5_new_zero", new_all, 0);
    chk("t5_no_err", err_pulses - e0, 0);
    csb_low(); send_bits(c1, 144); csb_high(); cyc(4);
    chk("t5_clean_pend", write_new_position, 1);
    chk("t5_clean_new", new_all, c1[143:0]);
    cyc(2);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("t5_tick_clear", write_new_position, 0);
    chk("t5_cap", cap_q, c1[143:0]);

    // sclk activity while chip select is high
    e0 = err_pulses;
    bad_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      spi_mosi = 1'($urandom_range(0, 1));
      cyc(2);
      spi_sclk = 1'b1;
      if (busy) bad_busy++;
      cyc(3);
      spi_sclk = 1'b0;
      if (busy) bad_busy++;
    end
    cyc(6);
    chk("t6_busy", bad_busy, 0);
    chk("t6_wnp", write_new_position, 0);
    chk("t6_new", new_all, c1[143:0]);
    chk("t6_err", err_pulses - e0, 0);

    chk("err_pulse_width", err_long, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
